// File: rtl/neuron_step_scheduler.sv
// Shares one Izhikevich datapath across N_NEURONS neurons. Each timestep walks the
// per-neuron register file in index order and reports fired neurons on a spike handshake.
module neuron_step_scheduler #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4,
  parameter int W         = 17,
  parameter int DP_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [W-1:0]     cfg_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_count,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  output logic [W-1:0]     dp_c,
  output logic [W-1:0]     dp_d,
  output logic [W-1:0]     dp_v,
  output logic [W-1:0]     dp_u,
  output logic [W-1:0]     dp_i,
  input  logic [W-1:0]     dp_v_prime,
  input  logic [W-1:0]     dp_u_prime,
  input  logic             dp_fired,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready
);

  localparam int               CNT_W     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(DP_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NEURONS - 1);
  localparam logic [W-1:0]     SAT_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     SAT_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WB, S_STALL, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             spike_valid_reg, spike_valid_next;
  logic [IDX_W-1:0] spike_idx_reg, spike_idx_next;
  logic [15:0]      step_count_reg;
  logic             issue_en, wb_en, spike_load, advance;

  logic [W-1:0] dp_a_reg, dp_b_reg, dp_c_reg, dp_d_reg, dp_v_reg, dp_u_reg, dp_i_reg;
  logic [W-1:0] rd_a, rd_b, rd_c, rd_d, rd_v, rd_u, rd_i;

  logic [W-1:0] a_mem [N_NEURONS];
  logic [W-1:0] b_mem [N_NEURONS];
  logic [W-1:0] c_mem [N_NEURONS];
  logic [W-1:0] d_mem [N_NEURONS];
  logic [W-1:0] v_mem [N_NEURONS];
  logic [W-1:0] u_mem [N_NEURONS];
  logic [W-1:0] i_mem [N_NEURONS];
  logic [W-1:0] acc_sum [N_NEURONS];
  logic [N_NEURONS-1:0] cfg_hit, wb_hit;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {x[W-1], x} + {y[W-1], y};
    if (s[W] != s[W-1]) return s[W] ? SAT_NEG : SAT_POS;
    return s[W-1:0];
  endfunction

  // Per-entry decode; indices beyond N_NEURONS simply match no entry.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_entry
    localparam logic [IDX_W-1:0] ENTRY = IDX_W'(gi);
    assign cfg_hit[gi] = cfg_we && (cfg_idx == ENTRY);
    assign wb_hit[gi]  = wb_en && (idx_reg == ENTRY);
    assign acc_sum[gi] = sat_add(i_mem[gi], cfg_data);
  end

  always_comb begin
    rd_a = '0; rd_b = '0; rd_c = '0; rd_d = '0;
    rd_v = '0; rd_u = '0; rd_i = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        rd_a = a_mem[k]; rd_b = b_mem[k]; rd_c = c_mem[k]; rd_d = d_mem[k];
        rd_v = v_mem[k]; rd_u = u_mem[k]; rd_i = i_mem[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    wait_cnt_next    = wait_cnt_reg;
    spike_valid_next = spike_valid_reg;
    spike_idx_next   = spike_idx_reg;
    issue_en         = 1'b0;
    wb_en            = 1'b0;
    spike_load       = 1'b0;
    advance          = 1'b0;

    if (spike_valid_reg && spike_ready) begin
      spike_valid_next = 1'b0;
      spike_idx_next   = '0;
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          idx_next   = '0;
        end
      end
      S_ISSUE: begin
        issue_en      = 1'b1;
        wait_cnt_next = WAIT_INIT;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_reg == '0) state_next = S_WB;
        else                    wait_cnt_next = wait_cnt_reg - 1'b1;
      end
      S_WB: begin
        wb_en = 1'b1;
        if (dp_fired && spike_valid_reg && !spike_ready) begin
          state_next = S_STALL;
        end else begin
          spike_load = dp_fired;
          advance    = 1'b1;
        end
      end
      S_STALL: begin
        // idx_reg is frozen here, so it doubles as the pending spike index.
        if (spike_ready) begin
          spike_load = 1'b1;
          advance    = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (spike_load) begin
      spike_valid_next = 1'b1;
      spike_idx_next   = idx_reg;
    end
    if (advance) begin
      if (idx_reg == LAST_IDX) begin
        state_next = S_DONE;
      end else begin
        idx_next   = idx_reg + 1'b1;
        state_next = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      wait_cnt_reg    <= '0;
      spike_valid_reg <= 1'b0;
      spike_idx_reg   <= '0;
      step_count_reg  <= '0;
      dp_a_reg <= '0; dp_b_reg <= '0; dp_c_reg <= '0; dp_d_reg <= '0;
      dp_v_reg <= '0; dp_u_reg <= '0; dp_i_reg <= '0;
    end else begin
      idx_reg         <= idx_next;
      wait_cnt_reg    <= wait_cnt_next;
      spike_valid_reg <= spike_valid_next;
      spike_idx_reg   <= spike_idx_next;
      if (state_reg == S_DONE) step_count_reg <= step_count_reg + 16'd1;
      if (issue_en) begin
        dp_a_reg <= rd_a; dp_b_reg <= rd_b; dp_c_reg <= rd_c; dp_d_reg <= rd_d;
        dp_v_reg <= rd_v; dp_u_reg <= rd_u; dp_i_reg <= rd_i;
      end
    end
  end

  // The writeback clear is ordered last so it beats a same-cycle accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        a_mem[k] <= '0; b_mem[k] <= '0; c_mem[k] <= '0; d_mem[k] <= '0;
        v_mem[k] <= '0; u_mem[k] <= '0; i_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_NEURONS; k++) begin
        if (cfg_hit[k] && state_reg == S_IDLE) begin
          case (cfg_sel)
            3'd0:    a_mem[k] <= cfg_data;
            3'd1:    b_mem[k] <= cfg_data;
            3'd2:    c_mem[k] <= cfg_data;
            3'd3:    d_mem[k] <= cfg_data;
            3'd4:    v_mem[k] <= cfg_data;
            3'd5:    u_mem[k] <= cfg_data;
            3'd6:    i_mem[k] <= cfg_data;
            default: ;
          endcase
        end
        if (cfg_hit[k] && cfg_sel == 3'd7) i_mem[k] <= acc_sum[k];
        if (wb_hit[k]) begin
          v_mem[k] <= dp_v_prime;
          u_mem[k] <= dp_u_prime;
          i_mem[k] <= '0;
        end
      end
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign step_count  = step_count_reg;
  assign spike_valid = spike_valid_reg;
  assign spike_idx   = spike_idx_reg;
  assign dp_a = dp_a_reg;
  assign dp_b = dp_b_reg;
  assign dp_c = dp_c_reg;
  assign dp_d = dp_d_reg;
  assign dp_v = dp_v_reg;
  assign dp_u = dp_u_reg;
  assign dp_i = dp_i_reg;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Directed bench for neuron_step_scheduler: 4 neurons behind a one-cycle stub datapath
// (v' = v + 0x100, u' = u, fired = d[0]); the register file is read back through dp_* operands.
module tb_neuron_step_scheduler;

  localparam int N   = 4;
  localparam int IW  = 3;
  localparam int W   = 17;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_sel = '0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [15:0]   step_count;
  logic [W-1:0]  dp_a, dp_b, dp_c, dp_d, dp_v, dp_u, dp_i;
  logic [W-1:0]  dp_v_prime = '0;
  logic [W-1:0]  dp_u_prime = '0;
  logic          dp_fired = 1'b0;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
  logic          spike_ready = 1'b1;

  always #5 clk = ~clk;

  neuron_step_scheduler #(.N_NEURONS(N), .IDX_W(IW), .W(W), .DP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done), .step_count(step_count),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
    .dp_v_prime(dp_v_prime), .dp_u_prime(dp_u_prime), .dp_fired(dp_fired),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready)
  );

  always @(posedge clk) begin
    dp_v_prime <= dp_v + 17'h00100;
    dp_u_prime <= dp_u;
    dp_fired   <= dp_d[0];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [IW-1:0] idx, input logic [W-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  logic [W-1:0]  cap_a [N], cap_b [N], cap_c [N], cap_d [N], cap_v [N], cap_u [N], cap_i [N];
  logic          sv_log [64];
  logic [IW-1:0] si_log [64];
  int busy_cnt, done_cnt, done_cyc, step_no = 0;

  // One timestep; optional mid-step cfg write, second start, reset and ready gating.
  task automatic run_step(input int acc_cyc, input logic [2:0] acc_sel, input logic [IW-1:0] acc_idx,
                          input logic [W-1:0] acc_data, input int restart_cyc, input int rst_cyc,
                          input int ready_cyc);
    bit fin;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; fin = 1'b0;
    step_no++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc % 3 == 1 && cyc / 3 < N) begin
        cap_a[cyc/3] = dp_a; cap_b[cyc/3] = dp_b; cap_c[cyc/3] = dp_c; cap_d[cyc/3] = dp_d;
        cap_v[cyc/3] = dp_v; cap_u[cyc/3] = dp_u; cap_i[cyc/3] = dp_i;
      end
      if (cyc < 64) begin sv_log[cyc] = spike_valid; si_log[cyc] = spike_idx; end
      cfg_we = (cyc == acc_cyc); cfg_sel = acc_sel; cfg_idx = acc_idx; cfg_data = acc_data;
      start = (cyc == restart_cyc);
      spike_ready = (ready_cyc < 0) || (cyc >= ready_cyc);
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (cyc > 0 && !busy) begin
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    cfg_we = 1'b0; start = 1'b0; spike_ready = 1'b1;
    check("step_terminates", 32'(fin), 32'd1);
    $display("step %0d: busy_cycles=%0d dones=%0d done_cyc=%0d step_count=%0d",
             step_no, busy_cnt, done_cnt, done_cyc, step_count);
  endtask

  logic [W-1:0] all_or;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Random activity, then reset.
    for (int k = 0; k < 6; k++) cfg_write(3'($urandom_range(0, 7)), IW'($urandom_range(0, 3)), W'($urandom));
    start = 1'b1; spike_ready = 1'($urandom);
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; spike_ready = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    check("rst_dp_or", 32'(dp_a | dp_b | dp_c | dp_d | dp_v | dp_u | dp_i), 32'd0);

    // Single timestep with operand sequencing.
    for (int k = 0; k < N; k++) begin
      cfg_write(3'd4, IW'(k), 17'h00A00);
      cfg_write(3'd6, IW'(k), 17'h00010 + W'(k));
    end
    cfg_write(3'd0, 3'd2, 17'h00300);
    cfg_write(3'd1, 3'd2, 17'h01400);
    cfg_write(3'd2, 3'd2, 17'h1BF00);
    cfg_write(3'd5, 3'd2, 17'h0B400);
    cfg_write(3'd6, 3'd2, 17'h00600);
    run_step(-1, 3'd0, 3'd0, '0, -1, -1, -1);
    check("s1_busy_cycles", 32'(busy_cnt), 32'd13);
    check("s1_dones", 32'(done_cnt), 32'd1);
    check("s1_done_cyc", 32'(done_cyc), 32'd12);
    check("s1_step_count", 32'(step_count), 32'd1);
    for (int k = 0; k < N; k++) check($sformatf("s1_v%0d", k), 32'(cap_v[k]), 32'h00A00);
    check("s1_a2", 32'(cap_a[2]), 32'h00300);
    check("s1_b2", 32'(cap_b[2]), 32'h01400);
    check("s1_c2", 32'(cap_c[2]), 32'h1BF00);
    check("s1_u2", 32'(cap_u[2]), 32'h0B400);
    check("s1_i2", 32'(cap_i[2]), 32'h00600);
    check("s1_i1", 32'(cap_i[1]), 32'h00011);
    check("s1_i3", 32'(cap_i[3]), 32'h00013);
    check("s1_a1", 32'(cap_a[1]), 32'h00000);

    // Out-of-range idx ignored; busy sel-4 write ignored; second start ignored.
    cfg_write(3'd4, 3'd5, 17'h07777);
    run_step(2, 3'd4, 3'd3, 17'h01234, 5, -1, -1);
    for (int k = 0; k < N; k++) begin
      check($sformatf("s2_v%0d", k), 32'(cap_v[k]), 32'h00B00);
      check($sformatf("s2_i%0d", k), 32'(cap_i[k]), 32'h00000);
    end
    check("s2_u2", 32'(cap_u[2]), 32'h0B400);
    check("s2_busy_cycles", 32'(busy_cnt), 32'd13);
    check("s2_dones", 32'(done_cnt), 32'd1);
    check("s2_step_count", 32'(step_count), 32'd2);

    // Busy accumulate to idx 0 after its writeback.
    run_step(5, 3'd7, 3'd0, 17'h00050, -1, -1, -1);
    check("s3_v3", 32'(cap_v[3]), 32'h00C00);
    check("s3_step_count", 32'(step_count), 32'd3);

    // Accumulate colliding with neuron 3's writeback clear.
    run_step(11, 3'd7, 3'd3, 17'h00040, -1, -1, -1);
    check("s4_i0_busy_acc", 32'(cap_i[0]), 32'h00050);
    check("s4_v0", 32'(cap_v[0]), 32'h00D00);

    // Saturating accumulate while idle.
    cfg_write(3'd7, 3'd0, 17'h0F000);
    cfg_write(3'd7, 3'd0, 17'h0F000);
    cfg_write(3'd6, 3'd1, 17'h10000);
    cfg_write(3'd7, 3'd1, 17'h1FFFF);
    cfg_write(3'd6, 3'd2, 17'h00100);
    cfg_write(3'd7, 3'd2, 17'h00050);
    run_step(-1, 3'd0, 3'd0, '0, -1, -1, -1);
    check("s5_i0_sat_pos", 32'(cap_i[0]), 32'h0FFFF);
    check("s5_i1_sat_neg", 32'(cap_i[1]), 32'h10000);
    check("s5_i2_acc", 32'(cap_i[2]), 32'h00150);
    check("s5_i3_collision", 32'(cap_i[3]), 32'h00000);
    check("s5_step_count", 32'(step_count), 32'd5);

    // Spike backpressure: neurons 1 and 2 fire, ready held low until cycle 20.
    cfg_write(3'd3, 3'd1, 17'h00001);
    cfg_write(3'd3, 3'd2, 17'h00001);
    run_step(-1, 3'd0, 3'd0, '0, -1, -1, 20);
    check("s6_valid_c6", 32'(sv_log[6]), 32'd1);
    check("s6_idx_c6", 32'(si_log[6]), 32'd1);
    check("s6_valid_c19", 32'(sv_log[19]), 32'd1);
    check("s6_idx_c19", 32'(si_log[19]), 32'd1);
    check("s6_valid_c21", 32'(sv_log[21]), 32'd1);
    check("s6_idx_c21", 32'(si_log[21]), 32'd2);
    check("s6_valid_c22", 32'(sv_log[22]), 32'd0);
    check("s6_done_cyc", 32'(done_cyc), 32'd24);
    check("s6_busy_cycles", 32'(busy_cnt), 32'd25);
    check("s6_dones", 32'(done_cnt), 32'd1);
    check("s6_step_count", 32'(step_count), 32'd6);

    // Reset during neuron 1's WAIT, then read everything back.
    run_step(-1, 3'd0, 3'd0, '0, -1, 4, -1);
    check("s7_busy", 32'(busy), 32'd0);
    check("s7_step_count", 32'(step_count), 32'd0);
    check("s7_spike_valid", 32'(spike_valid), 32'd0);
    check("s7_dp_v", 32'(dp_v), 32'd0);
    run_step(-1, 3'd0, 3'd0, '0, -1, -1, -1);
    all_or = '0;
    for (int k = 0; k < N; k++)
      all_or = all_or | cap_a[k] | cap_b[k] | cap_c[k] | cap_d[k] | cap_v[k] | cap_u[k] | cap_i[k];
    check("s8_v1", 32'(cap_v[1]), 32'd0);
    check("s8_regfile_or", 32'(all_or), 32'd0);
    check("s8_step_count", 32'(step_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_step_scheduler.md
Name: neuron_step_scheduler

Overview:
- Time-multiplexes one shared izhikevich datapath across N_NEURONS neurons.
- Holds per-neuron parameters (a, b, c, d), state (v, u) and input current (i) in a register file.
- On each `start`, walks every neuron in index order: issues its operands, waits for the datapath result, writes back v and u, clears i, and emits a spike event for each neuron that fired.
- Sits between the graph/config host and the izhikevich datapath instance.

Parameters:
- N_NEURONS, 16, number of neurons scheduled; must be ≥2.
- IDX_W, 4, neuron index width; must satisfy 2^IDX_W ≥ N_NEURONS.
- W, 17, fixed-point word width: 1 sign, 8 integer, 8 fraction bits, two's complement.
- DP_LAT, 1, datapath clock cycles from operand issue to valid v_prime/u_prime/fired; must be ≥1.

Ports:
- clk, input, 1, rising-edge clock for all logic.
- rst_n, input, 1, synchronous active-low reset.
- cfg_we, input, 1, config write strobe.
- cfg_sel, input, 3, target field: 0=a, 1=b, 2=c, 3=d, 4=v, 5=u, 6=i (replace), 7=i (saturating accumulate).
- cfg_idx, input, IDX_W, neuron index for the config write.
- cfg_data, input, W, config write data.
- start, input, 1, request one timestep over all neurons.
- busy, output, 1, high while a timestep is in progress.
- done, output, 1, one-cycle pulse when a timestep completes.
- step_count, output, 16, count of completed timesteps; wraps at 0xFFFF→0.
- dp_a, dp_b, dp_c, dp_d, dp_v, dp_u, dp_i, output, W each, registered operands to the datapath.
- dp_v_prime, dp_u_prime, input, W each, datapath results.
- dp_fired, input, 1, datapath spike flag.
- spike_valid, output, 1, spike event valid.
- spike_idx, output, IDX_W, index of the neuron that fired.
- spike_ready, input, 1, downstream accepts the spike event.

Behaviour:
- Reset (rst_n=0 at a clk edge): all register-file entries set to 0; FSM to IDLE; idx=0; busy, done, spike_valid, spike_idx, step_count and all dp_* outputs set to 0. Reset in any state aborts the timestep with no further writeback.
- FSM states:
  - IDLE: busy=0. `start`=1 → ISSUE with idx=0, and busy=1 from the next cycle.
  - ISSUE: dp_* ← entry[idx] (one cycle); then → WAIT with wait counter = DP_LAT-1.
  - WAIT: hold dp_* stable; counter decrements; at 0 → WB. The datapath outputs are sampled in WB, exactly DP_LAT edges after the operands were registered.
  - WB:
    - Always: v[idx] ← dp_v_prime; u[idx] ← dp_u_prime; i[idx] ← 0.
    - If dp_fired=1 and (spike_valid=0 or spike_ready=1): load spike_idx=idx and set spike_valid=1.
    - If dp_fired=1 and spike_valid=1 and spike_ready=0: → STALL, holding a latched copy of fired/idx. v/u/i are still written this cycle.
    - Otherwise: if idx=N_NEURONS-1 → DONE; else idx++ and → ISSUE.
  - STALL: stay until spike_ready=1; on that edge, load the new spike and continue as WB would (next neuron or DONE).
  - DONE: done=1 for exactly one cycle; step_count++; → IDLE. busy is high in ISSUE, WAIT, WB, STALL and DONE.
- Per-neuron cost without stall: DP_LAT+2 cycles. One timestep at defaults takes 48 cycles plus the DONE cycle.
- Spike handshake:
  - Transfer occurs when spike_valid && spike_ready at a clk edge.
  - spike_idx is held while spike_valid=1 and ready=0.
  - The single output register drops to 0 after a transfer unless a new spike loads on the same edge.
  - spike_valid may remain high after done.
- `start` while busy is ignored; it is not queued.
- cfg_we while busy: writes to sel 0–6 are ignored. Sel 7 (accumulate) is accepted for any idx, except when it collides with the WB clear of the same idx; in that case the clear wins and the accumulated value is lost.
- cfg_we while IDLE applies on the edge.
- Accumulate saturates to 0x0FFFF / 0x10000 (max positive / max negative) on signed overflow.
- Config writes with cfg_idx ≥ N_NEURONS are ignored.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles after random activity → busy=0, spike_valid=0, step_count=0, and all dp_* = 0 on the next cycle.
- Single timestep:
  - Setup: N_NEURONS=4, DP_LAT=1, stub datapath returning v_prime=v+0x00100, u_prime=u, fired=0; set v[k]=0x00A00; pulse start.
  - Expect: busy for 13 cycles, done one cycle, v[k]=0x00B00 for all k, i[k]=0, step_count=1.
- Operand sequencing: cfg a[2]=0x00300, b[2]=0x01400, u[2]=0x0B400, i[2]=0x00600 → during neuron 2's WAIT, dp_a/dp_b/dp_u/dp_i show exactly these values.
- Spike backpressure:
  - Setup: stub fires for neurons 1 and 2; spike_ready=0 until cycle 20.
  - Expect: spike_idx=1 stays valid, FSM stalls at neuron 2's WB; after ready, spike_idx=2 is presented next; done occurs late by the stall length.
- Accumulate saturation and collision:
  - Two sel-7 writes of 0x0F000 to idx 0 while IDLE → i[0]=0x0FFFF.
  - A sel-7 write to idx 3 in the same cycle as neuron 3's WB → i[3]=0.
- start while busy, plus mid-timestep reset:
  - A second start pulse at cycle 5 → exactly one done.
  - rst_n=0 during WAIT of neuron 1 → no writeback to v[1], and all register-file entries read back 0.
